// File: rtl/counter_nx.sv
// counter_nx: N-channel programmable interval counter.
// Each channel counts rising edges of its own asynchronous count clock (synchronised into clk),
// qualified by a gate, in one of four modes: one-shot, rate generator, square wave, free-running.
// Ports:
//   clk, rst           system clock, asynchronous active-low reset
//   cnt_clk            per-channel external count clocks (asynchronous)
//   counter_gate       per-channel count enable
//   counter_we         load strobe for the channel selected by counter_ch
//   counter_ch         channel select for load and readback
//   counter_mode       mode captured on load
//   counter_val        load / reload value
//   counter_outs       per-channel output waveform (registered)
//   counter_tc         per-channel terminal-count pulse (registered, one cycle)
//   counter_out        count of the selected channel (combinational, 0 for an invalid select)
module counter_nx #(
  parameter int unsigned N_CH  = 3,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CH_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  cnt_clk,
  input  logic [N_CH-1:0]  counter_gate,
  input  logic             counter_we,
  input  logic [CH_W-1:0]  counter_ch,
  input  logic [1:0]       counter_mode,
  input  logic [WIDTH-1:0] counter_val,
  output logic [N_CH-1:0]  counter_outs,
  output logic [N_CH-1:0]  counter_tc,
  output logic [WIDTH-1:0] counter_out
);

  typedef enum logic [1:0] {
    ModeOneShot = 2'd0,
    ModeRate    = 2'd1,
    ModeSquare  = 2'd2,
    ModeFree    = 2'd3
  } mode_e;

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  logic [N_CH-1:0]  sync1_q, sync2_q, prev_q;
  logic [N_CH-1:0]  tick, adv, load_sel;
  logic [N_CH-1:0]  armed_q, armed_d;
  logic [N_CH-1:0]  out_q, out_d;
  logic [N_CH-1:0]  tc_q, tc_d;
  logic [WIDTH-1:0] count_q [N_CH];
  logic [WIDTH-1:0] count_d [N_CH];
  logic [WIDTH-1:0] reload_q [N_CH];
  logic [WIDTH-1:0] reload_d [N_CH];
  mode_e            mode_q [N_CH];
  mode_e            mode_d [N_CH];
  logic [31:0]      ch_ext;
  mode_e            load_mode;
  logic             load_out;

  // Two-flop synchroniser plus a previous-value flop for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= cnt_clk;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign tick      = sync2_q & ~prev_q;
  assign adv       = tick & armed_q & counter_gate;
  assign ch_ext    = 32'(counter_ch);
  assign load_mode = mode_e'(counter_mode);

  always_comb begin
    load_out = 1'b1;
    unique case (load_mode)
      ModeOneShot: load_out = 1'b0;
      ModeRate:    load_out = 1'b1;
      ModeSquare:  load_out = 1'b1;
      ModeFree:    load_out = counter_val[WIDTH-1];
    endcase
  end

  // Out-of-range selects match no channel, so the load is dropped.
  always_comb begin
    load_sel = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      load_sel[i] = counter_we && (ch_ext == i);
    end
  end

  always_comb begin
    counter_out = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (ch_ext == i) counter_out = count_q[i];
    end
  end

  always_comb begin
    armed_d = armed_q;
    out_d   = out_q;
    tc_d    = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      count_d[i]  = count_q[i];
      reload_d[i] = reload_q[i];
      mode_d[i]   = mode_q[i];
      // A load on this channel discards any coincident tick.
      if (load_sel[i]) begin
        count_d[i]  = counter_val;
        reload_d[i] = counter_val;
        mode_d[i]   = load_mode;
        armed_d[i]  = 1'b1;
        out_d[i]    = load_out;
      end else begin
        // Rate-generator low pulse lasts one clk cycle only.
        if (mode_q[i] == ModeRate && armed_q[i]) out_d[i] = 1'b1;
        if (adv[i]) begin
          unique case (mode_q[i])
            ModeOneShot: begin
              if (count_q[i] == One) begin
                count_d[i] = '0;
                out_d[i]   = 1'b1;
                tc_d[i]    = 1'b1;
                armed_d[i] = 1'b0;
              end else begin
                count_d[i] = count_q[i] - One;
              end
            end
            ModeRate: begin
              if (count_q[i] == One) begin
                count_d[i] = reload_q[i];
                out_d[i]   = 1'b0;
                tc_d[i]    = 1'b1;
              end else begin
                count_d[i] = count_q[i] - One;
                out_d[i]   = 1'b1;
              end
            end
            ModeSquare: begin
              if (count_q[i] == One) begin
                count_d[i] = reload_q[i];
                out_d[i]   = ~out_q[i];
                tc_d[i]    = 1'b1;
              end else begin
                count_d[i] = count_q[i] - One;
              end
            end
            ModeFree: begin
              count_d[i] = count_q[i] + One;
              tc_d[i]    = &count_q[i];
              out_d[i]   = count_d[i][WIDTH-1];
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed_q <= '0;
      out_q   <= '0;
      tc_q    <= '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        count_q[i]  <= '0;
        reload_q[i] <= '0;
        mode_q[i]   <= ModeOneShot;
      end
    end else begin
      armed_q <= armed_d;
      out_q   <= out_d;
      tc_q    <= tc_d;
      for (int unsigned i = 0; i < N_CH; i++) begin
        count_q[i]  <= count_d[i];
        reload_q[i] <= reload_d[i];
        mode_q[i]   <= mode_d[i];
      end
    end
  end

  assign counter_outs = out_q;
  assign counter_tc   = tc_q;

endmodule

// File: tb/tb_counter_nx.sv
module tb_counter_nx;

  localparam int NCH = 3;
  localparam int W   = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [NCH-1:0] cnt_clk = '0;
  logic [NCH-1:0] counter_gate = '1;
  logic           counter_we = 1'b0;
  logic [1:0]     counter_ch = '0;
  logic [1:0]     counter_mode = '0;
  logic [W-1:0]   counter_val = '0;
  logic [NCH-1:0] counter_outs;
  logic [NCH-1:0] counter_tc;
  logic [W-1:0]   counter_out;

  counter_nx #(
    .N_CH (NCH),
    .WIDTH(W),
    .CH_W (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cnt_clk     (cnt_clk),
    .counter_gate(counter_gate),
    .counter_we  (counter_we),
    .counter_ch  (counter_ch),
    .counter_mode(counter_mode),
    .counter_val (counter_val),
    .counter_outs(counter_outs),
    .counter_tc  (counter_tc),
    .counter_out (counter_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Observed tc pulses and mode-1 low cycles on channel 0.
  int tc_seen [NCH] = '{0, 0, 0};
  int low_seen = 0;
  bit watch_low = 1'b0;

  always @(negedge clk) begin
    for (int i = 0; i < NCH; i++) if (counter_tc[i]) tc_seen[i]++;
    if (watch_low && rst && !counter_outs[0]) low_seen++;
  end

  // Reference model: state per channel, updated once per effective tick.
  logic [W-1:0] m_cnt [NCH];
  logic [W-1:0] m_rl [NCH];
  logic [1:0]   m_mode [NCH];
  bit           m_armed [NCH];
  bit           m_out [NCH];
  int           m_tc [NCH];

  task automatic m_reset();
    for (int i = 0; i < NCH; i++) begin
      m_cnt[i] = '0; m_rl[i] = '0; m_mode[i] = '0; m_armed[i] = 0; m_out[i] = 0;
    end
  endtask

  task automatic m_load(input int ch, input logic [1:0] mode, input logic [W-1:0] val);
    if (ch < NCH) begin
      m_cnt[ch] = val; m_rl[ch] = val; m_mode[ch] = mode; m_armed[ch] = 1;
      m_out[ch] = (mode == 2'd0) ? 1'b0 : (mode == 2'd3) ? val[W-1] : 1'b1;
    end
  endtask

  task automatic m_tick(input int i);
    if (!m_armed[i]) return;
    case (m_mode[i])
      2'd0: if (m_cnt[i] == 1) begin
              m_cnt[i] = 0; m_out[i] = 1; m_tc[i]++; m_armed[i] = 0;
            end else m_cnt[i] = m_cnt[i] - 1;
      2'd1: begin
              if (m_cnt[i] == 1) begin m_cnt[i] = m_rl[i]; m_tc[i]++; end
              else m_cnt[i] = m_cnt[i] - 1;
              m_out[i] = 1;
            end
      2'd2: if (m_cnt[i] == 1) begin
              m_cnt[i] = m_rl[i]; m_out[i] = !m_out[i]; m_tc[i]++;
            end else m_cnt[i] = m_cnt[i] - 1;
      default: begin
              m_cnt[i] = m_cnt[i] + 1;
              if (m_cnt[i] == 0) m_tc[i]++;
              m_out[i] = m_cnt[i][W-1];
            end
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < NCH; i++) begin
      counter_ch = 2'(i);
      #1;
      check($sformatf("%s count ch%0d", tag, i), 32'(counter_out), 32'(m_cnt[i]));
      check($sformatf("%s tc ch%0d", tag, i), 32'(tc_seen[i]), 32'(m_tc[i]));
    end
    check({tag, " outs"}, 32'(counter_outs), 32'({m_out[2], m_out[1], m_out[0]}));
  endtask

  task automatic do_load(input int ch, input logic [1:0] mode, input logic [W-1:0] val);
    @(negedge clk);
    counter_we = 1'b1; counter_ch = 2'(ch); counter_mode = mode; counter_val = val;
    @(negedge clk);
    counter_we = 1'b0;
    m_load(ch, mode, val);
  endtask

  // High for two clk cycles, low for two; the tick lands on the edge after the falling drive.
  task automatic pulse(input logic [NCH-1:0] mask);
    @(negedge clk); cnt_clk = mask;
    repeat (2) @(negedge clk); cnt_clk = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < NCH; i++) if (mask[i] && counter_gate[i]) m_tick(i);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_reset();
    for (int i = 0; i < NCH; i++) m_tc[i] = 0;
    repeat (3) @(negedge clk);
    check_all("reset");
    check("reset tc", 32'(counter_tc), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Mode 0: ch0 val 5, exact latency on the 5th tick.
    do_load(0, 2'd0, 8'd5);
    check_all("m0 load");
    repeat (4) pulse(3'b001);
    check_all("m0 4 ticks");
    @(negedge clk); cnt_clk = 3'b001; counter_ch = 2'd0;
    @(negedge clk);
    @(negedge clk);
    #1 check("m0 e+1 count", 32'(counter_out), 32'd1);
    check("m0 e+1 out", 32'(counter_outs[0]), 32'd0);
    @(negedge clk); cnt_clk = '0;
    #1 check("m0 e+2 count", 32'(counter_out), 32'd0);
    check("m0 e+2 out", 32'(counter_outs[0]), 32'd1);
    check("m0 e+2 tc", 32'(counter_tc[0]), 32'd1);
    @(negedge clk);
    #1 check("m0 tc one cycle", 32'(counter_tc[0]), 32'd0);
    m_tick(0);
    repeat (2) @(negedge clk);
    check_all("m0 done");
    repeat (3) pulse(3'b001);
    check_all("m0 after");

    // Mode 2: ch1 val 3, 12 ticks, then gate low for 4.
    do_load(1, 2'd2, 8'd3);
    for (int k = 0; k < 12; k++) begin
      pulse(3'b010);
      check_all($sformatf("m2 tick%0d", k));
    end
    check("m2 tc total", 32'(tc_seen[1]), 32'd4);
    @(negedge clk); counter_gate = 3'b101;
    repeat (4) pulse(3'b010);
    check_all("m2 gated");
    @(negedge clk); counter_gate = 3'b111;
    pulse(3'b010);
    check_all("m2 resume");

    // Mode 3: ch2 from FE wraps through 00.
    do_load(2, 2'd3, 8'hFE);
    check_all("m3 load");
    for (int k = 0; k < 3; k++) begin
      pulse(3'b100);
      check_all($sformatf("m3 tick%0d", k));
    end

    // Load collides with a ch1 tick: load wins.
    @(negedge clk); cnt_clk = 3'b010;
    @(negedge clk);
    @(negedge clk);
    counter_we = 1'b1; counter_ch = 2'd1; counter_mode = 2'd1; counter_val = 8'd7;
    cnt_clk = '0;
    @(negedge clk); counter_we = 1'b0;
    m_load(1, 2'd1, 8'd7);
    @(negedge clk);
    check_all("collide");

    // Mode 1: ch0 val 4, one low cycle every 4 ticks.
    do_load(0, 2'd1, 8'd4);
    low_seen = 0; watch_low = 1'b1;
    for (int k = 0; k < 8; k++) pulse(3'b001);
    watch_low = 1'b0;
    check("m1 low cycles", 32'(low_seen), 32'd2);
    check_all("m1");

    // Invalid channel write.
    do_load(3, 2'd0, 8'h55);
    counter_ch = 2'd3;
    #1 check("invalid sel out", 32'(counter_out), 32'd0);
    check_all("invalid wr");

    // Asynchronous reset mid-count.
    @(negedge clk); cnt_clk = 3'b111;
    counter_ch = 2'd2;
    #2 rst = 1'b0;
    #1 check("async rst out", 32'(counter_out), 32'd0);
    check("async rst outs", 32'(counter_outs), 32'd0);
    check("async rst tc", 32'(counter_tc), 32'd0);
    m_reset();
    @(negedge clk); rst = 1'b1; cnt_clk = '0;
    repeat (3) @(negedge clk);
    repeat (10) pulse(3'b111);
    check_all("post rst idle");

    // Randomised phase.
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        do_load(int'($urandom_range(0, 3)), 2'($urandom),
                ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 4)) : 8'($urandom));
      end else begin
        @(negedge clk);
        counter_gate = 3'($urandom) | 3'($urandom);
        pulse(3'($urandom));
      end
      check_all($sformatf("rand%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
